// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential fetches and buffers {pc, insn} pairs for decode.
// Latency: request in cycle N is enqueued in N+1 and presented on valid_o in N+2 (no bypass).
// Backpressure: issue is credit-gated on count+inflight < DEPTH; a full queue with ready_i=0 holds.
module ifetch_queue #(
    parameter int                 AWIDTH   = 32,
    parameter int                 DWIDTH   = 32,
    parameter logic [AWIDTH-1:0]  BASEADDR = AWIDTH'(32'h01000000),
    parameter int                 DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req_o,
    output logic [AWIDTH-1:0]           imem_addr_o,
    input  logic [DWIDTH-1:0]           imem_rdata_i,
    input  logic                        redirect_i,
    input  logic [AWIDTH-1:0]           redirect_pc_i,
    input  logic                        halt_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [AWIDTH-1:0]           pc_o,
    output logic [DWIDTH-1:0]           insn_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AWIDTH-1:0] fetch_pc;
    logic [AWIDTH-1:0] inflight_pc;   // address of the request whose data arrives this cycle
    logic              inflight;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;

    logic [AWIDTH-1:0] mem_pc   [DEPTH];
    logic [DWIDTH-1:0] mem_insn [DEPTH];

    logic [CW:0]       credits_used;
    logic              issue;
    logic              enq;
    logic              deq;

    // Credit check: outstanding request plus stored entries must leave room for one more.
    always_comb begin
        credits_used = {1'b0, count} + {{CW{1'b0}}, inflight};
        issue        = !rst && !redirect_i && !halt_i && (credits_used < (CW+1)'(DEPTH));
        enq          = inflight && !redirect_i;
        valid_o      = (count != '0) && !redirect_i;
        deq          = valid_o && ready_i;
    end

    // Output view of the head entry; zeros when empty so decode never sees stale data.
    always_comb begin
        imem_req_o  = issue;
        imem_addr_o = fetch_pc;
        count_o     = count;
        pc_o        = (count != '0) ? mem_pc[head]   : '0;
        insn_o      = (count != '0) ? mem_insn[head] : '0;
    end

    // Fetch PC and in-flight tracking; redirect overrides everything and word-aligns the target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= BASEADDR;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_i) begin
            fetch_pc    <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
            inflight    <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + AWIDTH'(4);
            end
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PW'(1);
            if (deq) head <= head + PW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; validity is tracked by count, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_pc[tail]   <= inflight_pc;
            mem_insn[tail] <= imem_rdata_i;
        end
    end

endmodule
